// File: rtl/tl_pkg.sv
// Shared TileLink-UL types for the memory responder: channel opcodes and the
// width-independent header carried with every queued A request.
package tl_pkg;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  // Header of a queued request; the responder wraps it with the
  // parameter-sized source/index/mask/data fields.
  typedef struct packed {
    tl_a_op_e opcode;
    logic     denied;
  } tl_a_req_t;

  function automatic logic a_op_supported(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
  endfunction

  // Unsupported opcodes are serviced as a denied Get.
  function automatic tl_a_op_e a_op_decode(input logic [2:0] op);
    tl_a_op_e res;
    case (op)
      3'd0:    res = PUT_FULL;
      3'd1:    res = PUT_PARTIAL;
      default: res = GET;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tl_sync_fifo.sv
// Synchronous FIFO with registered pointers; a push is accepted while full
// when a pop happens in the same cycle.
module tl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/tl_mem_responder.sv
// TileLink-UL slave returning one-beat D responses from a line-addressed
// array, with an in-order request queue and a fixed programmable latency.
module tl_mem_responder
  import tl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 512,
  parameter int                    SOURCE_W   = 1,
  parameter int                    MEM_LINES  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h8000_0000,
  parameter int                    LATENCY    = 2,
  parameter int                    DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [2:0]              a_opcode,
  input  logic [SOURCE_W-1:0]     a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [DATA_WIDTH/8-1:0] a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [2:0]              d_opcode,
  output logic [SOURCE_W-1:0]     d_source,
  output logic                    d_denied,
  output logic [DATA_WIDTH-1:0]   d_data
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(MASK_W);
  localparam int IDX_W  = $clog2(MEM_LINES);

  typedef struct packed {
    tl_a_req_t             hdr;
    logic [SOURCE_W-1:0]   source;
    logic [IDX_W-1:0]      index;
    logic [MASK_W-1:0]     mask;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e   state;
  state_e   state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic     pop;
  logic     enter_resp;

  logic [ADDR_WIDTH-1:0] offs;
  logic [ADDR_WIDTH-1:0] line_a;
  logic                  in_range;
  logic                  push;
  logic                  full;
  logic                  empty;
  entry_t                wr_entry;
  entry_t                head;
  entry_t                cur;
  entry_t                acc;
  logic [EW-1:0]         head_bits;

  tl_d_op_e              d_op_q;
  logic [DATA_WIDTH-1:0] mem [MEM_LINES];

  // A-channel decode
  assign offs     = a_address - BASE_ADDR;
  assign line_a   = offs >> OFF_W;
  assign in_range = (a_address >= BASE_ADDR) && (line_a < ADDR_WIDTH'(MEM_LINES));
  assign a_ready  = !full && !rst;
  assign push     = a_valid && a_ready;

  always_comb begin
    wr_entry            = '0;
    wr_entry.hdr.opcode = a_op_decode(a_opcode);
    wr_entry.hdr.denied = !in_range || !a_op_supported(a_opcode);
    wr_entry.source     = a_source;
    wr_entry.index      = line_a[IDX_W-1:0];
    wr_entry.mask       = a_mask;
    wr_entry.data       = a_data;
  end

  tl_sync_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head_bits),
    .full  (full),
    .empty (empty)
  );

  assign head = entry_t'(head_bits);

  // With zero latency RESP is entered straight from the pop, so the array is
  // accessed with the FIFO head rather than the registered entry.
  assign acc = (state == WAIT) ? cur : head;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pop        = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) pop = 1'b1;
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        if (cnt == 4'd1) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (d_ready) begin
          if (!empty) pop = 1'b1;
          else        state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      cnt_n = 4'(LATENCY);
      if (LATENCY == 0) begin
        state_n    = RESP;
        enter_resp = 1'b1;
      end else begin
        state_n = WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) cur <= head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_op_q   <= ACCESS_ACK;
      d_source <= '0;
      d_denied <= 1'b0;
      d_data   <= '0;
    end else if (enter_resp) begin
      d_op_q   <= (acc.hdr.opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
      d_source <= acc.source;
      d_denied <= acc.hdr.denied;
      d_data   <= (acc.hdr.opcode == GET && !acc.hdr.denied) ? mem[acc.index] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && !rst && !acc.hdr.denied && acc.hdr.opcode != GET) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (acc.hdr.opcode == PUT_FULL || acc.mask[b]) begin
          mem[acc.index][b*8 +: 8] <= acc.data[b*8 +: 8];
        end
      end
    end
  end

  assign d_valid  = (state == RESP);
  assign d_opcode = d_op_q;

endmodule

// File: tb/tb_tl_mem_responder.sv
// Directed bench for tl_mem_responder: two instances (latency 2 and 0), each
// checked every cycle against a transaction-level response model.
module tb_tl_mem_responder;

  localparam logic [63:0]  BASE = 64'h8000_0000;
  localparam logic [511:0] P0   = {64{8'hA5}};
  localparam logic [511:0] P3   = {16{32'h0123_4567}};
  localparam logic [511:0] P3W  = {{15{32'h0123_4567}}, 32'h0123_455A};

  typedef struct {
    int           acc;
    logic [2:0]   op;
    logic         src;
    logic         den;
    logic [511:0] data;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         a_valid   [2];
  logic         a_ready   [2];
  logic [2:0]   a_opcode  [2];
  logic [0:0]   a_source  [2];
  logic [63:0]  a_address [2];
  logic [63:0]  a_mask    [2];
  logic [511:0] a_data    [2];
  logic         d_valid   [2];
  logic         d_ready   [2];
  logic [2:0]   d_opcode  [2];
  logic [0:0]   d_source  [2];
  logic         d_denied  [2];
  logic [511:0] d_data    [2];

  int cyc;
  int errors;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 2 : 0;

    exp_t         q [$];
    logic [511:0] mm [int];
    int           last_fire;
    bit           have_fire;
    int           vcnt;
    int           rise;
    int           run;
    int           lastrun;
    bit           prev_v;
    logic [511:0] last_rd_data;
    logic         last_rd_den;

    tl_mem_responder #(
      .LATENCY(LAT),
      .DEPTH  (4)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid[g]),
      .a_ready   (a_ready[g]),
      .a_opcode  (a_opcode[g]),
      .a_source  (a_source[g]),
      .a_address (a_address[g]),
      .a_mask    (a_mask[g]),
      .a_data    (a_data[g]),
      .d_valid   (d_valid[g]),
      .d_ready   (d_ready[g]),
      .d_opcode  (d_opcode[g]),
      .d_source  (d_source[g]),
      .d_denied  (d_denied[g]),
      .d_data    (d_data[g])
    );

    always @(negedge clk) begin
      exp_t             e;
      longint unsigned  off;
      longint unsigned  ln;
      bit               inr;
      bit               sup;
      int               v;
      bit               ev;
      logic [511:0]     tmp;

      // expected valid: request latency after accept, or after previous fire
      ev = 1'b0;
      if (q.size() > 0) begin
        v = q[0].acc + 2 + LAT;
        if (have_fire && (last_fire + 1 + LAT > v)) v = last_fire + 1 + LAT;
        ev = (cyc >= v);
      end
      chk($sformatf("i%0d.d_valid@%0d", g, cyc), d_valid[g], ev);
      if (ev && d_valid[g]) begin
        chk($sformatf("i%0d.d_opcode", g), d_opcode[g], q[0].op);
        chk($sformatf("i%0d.d_source", g), d_source[g], q[0].src);
        chk($sformatf("i%0d.d_denied", g), d_denied[g], q[0].den);
        if (q[0].op == 3'd1) chk($sformatf("i%0d.d_data", g), d_data[g], q[0].data);
      end

      if (d_valid[g]) begin
        vcnt++;
        run++;
        if (!prev_v) rise = cyc;
        if (d_ready[g] && d_opcode[g] == 3'd1) begin
          last_rd_data = d_data[g];
          last_rd_den  = d_denied[g];
        end
      end else begin
        if (prev_v) lastrun = run;
        run = 0;
      end
      prev_v = d_valid[g];

      if (d_valid[g] && d_ready[g] && q.size() > 0) begin
        void'(q.pop_front());
        last_fire = cyc;
        have_fire = 1'b1;
      end

      if (a_valid[g] && a_ready[g]) begin
        off   = a_address[g] - BASE;
        ln    = off / 64;
        inr   = (a_address[g] >= BASE) && (ln < 4096);
        sup   = a_opcode[g] inside {3'd0, 3'd1, 3'd4};
        e.acc = cyc;
        e.src = a_source[g][0];
        e.den = !inr || !sup;
        e.op  = (sup && a_opcode[g] != 3'd4) ? 3'd0 : 3'd1;
        e.data = '0;
        if (e.op == 3'd1 && !e.den) e.data = mm[int'(ln)];
        if (e.op == 3'd0 && !e.den) begin
          if (a_opcode[g] == 3'd0) begin
            mm[int'(ln)] = a_data[g];
          end else begin
            tmp = mm[int'(ln)];
            for (int b = 0; b < 64; b++) if (a_mask[g][b]) tmp[b*8 +: 8] = a_data[g][b*8 +: 8];
            mm[int'(ln)] = tmp;
          end
        end
        q.push_back(e);
      end

      if (rst) begin
        chk($sformatf("i%0d.a_ready_in_rst", g), a_ready[g], 1'b0);
        q.delete();
        have_fire = 1'b0;
      end
    end
  end

  task automatic send(input int i, input logic [2:0] op, input logic src, input logic [63:0] addr,
                      input logic [63:0] mask, input logic [511:0] data);
    bit done;
    done         = 1'b0;
    a_valid[i]   = 1'b1;
    a_opcode[i]  = op;
    a_source[i]  = src;
    a_address[i] = addr;
    a_mask[i]    = mask;
    a_data[i]    = data;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (a_ready[i]) done = 1'b1;
      @(posedge clk);
      #1;
    end
    a_valid[i] = 1'b0;
    if (!done) chk($sformatf("i%0d.send_timeout", i), 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    int acc;
    int snap;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_valid[i] = 1'b0; a_opcode[i] = '0; a_source[i] = '0; a_address[i] = '0;
      a_mask[i] = '0; a_data[i] = '0; d_ready[i] = 1'b1;
    end
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d.rst_d_valid", i), d_valid[i], 1'b0);
      chk($sformatf("i%0d.rst_d_opcode", i), d_opcode[i], 3'd0);
      chk($sformatf("i%0d.rst_d_source", i), d_source[i], 1'b0);
      chk($sformatf("i%0d.rst_d_denied", i), d_denied[i], 1'b0);
      chk($sformatf("i%0d.rst_d_data", i), d_data[i], '0);
    end
    idle(1);

    // Get latency on the latency-2 instance
    send(0, 3'd0, 1'b0, BASE, '1, P0);
    send(0, 3'd0, 1'b0, BASE + 64'd192, '1, P3);
    idle(10);
    send(0, 3'd4, 1'b1, BASE, '0, '0);
    t = cyc - 1;
    idle(8);
    chk("get_latency_rise", g_inst[0].rise, t + 4);
    chk("get_data", g_inst[0].last_rd_data, P0);
    chk("get_denied", g_inst[0].last_rd_den, 1'b0);

    // Partial write then read of line 3
    send(0, 3'd1, 1'b0, BASE + 64'd192, 64'h1, {{63{8'hFF}}, 8'h5A});
    send(0, 3'd4, 1'b0, BASE + 64'd200, '0, '0);
    idle(12);
    chk("partial_readback", g_inst[0].last_rd_data, P3W);

    // Backpressure: no pops, 5 accepts fit (4 queued + 1 in RESP)
    d_ready[0]  = 1'b0;
    a_valid[0]  = 1'b1;
    a_opcode[0] = 3'd4;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      a_source[0]  = acc[0];
      a_address[0] = acc[0] ? BASE + 64'd192 : BASE;
      @(negedge clk);
      if (a_ready[0]) acc++;
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", acc, 5);
    chk("bp_a_ready_low", a_ready[0], 1'b0);
    d_ready[0] = 1'b1;
    for (int k = 0; k < 20 && acc < 6; k++) begin
      a_source[0]  = acc[0];
      a_address[0] = acc[0] ? BASE + 64'd192 : BASE;
      @(negedge clk);
      if (a_ready[0]) acc++;
      @(posedge clk);
      #1;
    end
    a_valid[0] = 1'b0;
    chk("bp_accepted_after", acc, 6);
    idle(40);

    // Out-of-range and unsupported opcode requests
    send(0, 3'd4, 1'b1, BASE - 64'd64, '0, '0);
    idle(8);
    chk("oor_get_data", g_inst[0].last_rd_data, '0);
    chk("oor_get_denied", g_inst[0].last_rd_den, 1'b1);
    send(0, 3'd0, 1'b0, BASE + 64'd4096 * 64'd64, '1, {64{8'hEE}});
    send(0, 3'd2, 1'b1, BASE, '0, '0);
    send(0, 3'd4, 1'b0, BASE, '0, '0);
    idle(20);
    chk("oor_line0_intact", g_inst[0].last_rd_data, P0);
    chk("oor_line0_denied", g_inst[0].last_rd_den, 1'b0);

    // Streaming on the zero-latency instance
    send(1, 3'd0, 1'b0, BASE, '1, P0);
    idle(10);
    send(1, 3'd4, 1'b0, BASE, '0, '0);
    t = cyc - 1;
    for (int k = 1; k < 8; k++) send(1, 3'd4, k[0], BASE, '0, '0);
    idle(10);
    chk("stream_rise", g_inst[1].rise, t + 2);
    chk("stream_run", g_inst[1].lastrun, 8);
    chk("stream_data", g_inst[1].last_rd_data, P0);

    // Reset with requests queued
    d_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 3'd4, k[0], BASE, '0, '0);
    idle(6);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_d_valid", d_valid[0], 1'b0);
    snap = g_inst[0].vcnt;
    idle(1);
    d_ready[0] = 1'b1;
    idle(10);
    chk("rst_no_stale", g_inst[0].vcnt, snap);
    send(0, 3'd4, 1'b1, BASE + 64'd192, '0, '0);
    idle(10);
    chk("rst_new_get_data", g_inst[0].last_rd_data, P3W);
    chk("rst_new_get_count", g_inst[0].vcnt, snap + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tl_mem_responder.md
# tl_mem_responder

TileLink-UL responder (slave end) that services the cacheline-wide A-channel requests issued by `aura_core` on its instruction and data buses. It returns D-channel responses from an internal line-addressed memory array. Each bus gets its own instance in the simulation top. The block buffers requests in order, applies a programmable fixed access latency, and backpressures the core when its queue is full.

## Interface
Parameters:
- `ADDR_WIDTH`, 64: A-channel byte-address width.
- `DATA_WIDTH`, 512: line/beat width in bits; one beat per transfer.
- `SOURCE_W`, 1: source-ID width, sized for 2 masters.
- `MEM_LINES`, 4096: number of lines in the array; power of two.
- `BASE_ADDR`, 64'h8000_0000: byte address of line 0.
- `LATENCY`, 2: extra wait cycles per access; legal range 0..15.
- `DEPTH`, 4: request-queue entries; power of two, ≥2.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_valid` in 1: A-channel request valid.
- `a_ready` out 1: A-channel accept.
- `a_opcode` in 3: request opcode; 0 = PutFullData, 1 = PutPartialData, 4 = Get.
- `a_source` in SOURCE_W: requester ID.
- `a_address` in ADDR_WIDTH: byte address.
- `a_mask` in DATA_WIDTH/8: byte enables.
- `a_data` in DATA_WIDTH: write data.
- `d_valid` out 1: D-channel response valid.
- `d_ready` in 1: D-channel accept.
- `d_opcode` out 3: response opcode; 0 = AccessAck, 1 = AccessAckData.
- `d_source` out SOURCE_W: echoed `a_source`.
- `d_denied` out 1: address out of range.
- `d_data` out DATA_WIDTH: read data.

## Operation
- A handshake fires when `a_valid && a_ready`. A fired request pushes {opcode, source, line index, in-range, mask, data} into the queue.
- `a_ready` = queue not full and not `rst`. An A fire and a queue pop may occur in the same cycle, including when the queue is full.
- Line index = (`a_address` − `BASE_ADDR`) >> log2(DATA_WIDTH/8). The low address bits are ignored and `a_size` is not supported: every access is one full line.
- A request is in range when `a_address` ≥ `BASE_ADDR` and index < `MEM_LINES`.
- FSM with three states: IDLE, WAIT, RESP.
  - IDLE: if the queue is non-empty, pop the head and load `cnt` = `LATENCY`. Go to RESP if `LATENCY` = 0, otherwise go to WAIT.
  - WAIT: decrement `cnt`. On the cycle `cnt` = 1, go to RESP.
  - RESP: `d_valid` = 1. On a D fire, if the queue is non-empty, pop and reload as in IDLE; otherwise go to IDLE.
- The array access happens on the edge that enters RESP.
  - Get: `d_data` ← mem[index]; `d_opcode` = 1.
  - PutFull: write every byte regardless of mask; `d_opcode` = 0.
  - PutPartial: write only the bytes whose `a_mask` bit is set; `d_opcode` = 0.
- Out-of-range request: no array write; `d_denied` = 1; `d_data` = 0; opcode chosen as for an in-range request.
- Unsupported opcode: treat as Get with `d_denied` = 1.
- D outputs are registered and held stable while `d_valid && !d_ready`. Responses are strictly in request order.

## Timing
- Reset values: `d_valid` 0, `d_opcode` 0, `d_source` 0, `d_denied` 0, `d_data` 0, `a_ready` 0 while `rst` is high. The queue is emptied and the FSM returns to IDLE.
- Array contents are not reset. They are preloaded by `$readmemh` in simulation.
- Latency: with an empty queue and the FSM in IDLE, an A fire in cycle t gives `d_valid` first high in cycle t+2+`LATENCY`.
- Throughput: with `LATENCY` = 0 and `d_ready` held high, one response per cycle.
- `rst` asserted mid-transaction drops all queued and in-flight requests. A write whose RESP entry edge has already passed remains committed.
- A read of a line issued after a write to the same line returns the new data, because accesses are serialized in order.

## Structure
- Package `tl_pkg`:
  - A opcode enum: PUT_FULL = 0, PUT_PARTIAL = 1, GET = 4.
  - D opcode enum: ACCESS_ACK = 0, ACCESS_ACK_DATA = 1.
  - Packed struct `tl_a_req_t` holding the queue entry.
- One sub-module, `tl_sync_fifo`: parameterized width and depth, synchronous reset, push/pop/full/empty, same-cycle push+pop when full.
- The FSM, latency counter and array stay in `tl_mem_responder`.

## Test plan
- **Get latency:** preload mem[0] = 0xA5 pattern; Get at `BASE_ADDR`, `LATENCY` = 2, source 1 in cycle t → `d_valid` at t+4 with `d_opcode` = 1, `d_source` = 1, `d_data` = pattern, `d_denied` = 0.
- **Partial write then read:** PutPartial to line 3 with mask 0x1 and data byte 0x5A, then Get line 3 → AccessAck, then data with byte0 = 0x5A and all other bytes unchanged.
- **Backpressure:** `DEPTH` = 4, `d_ready` = 0, issue 6 Gets → `a_ready` drops after 5 accepted (4 queued + 1 in RESP). Raise `d_ready` → 6 responses in order with matching sources.
- **Out of range:** Get at `BASE_ADDR` − 64 and Put at index `MEM_LINES` → both responses have `d_denied` = 1, the Get's `d_data` = 0, and no array line changes.
- **Streaming:** `LATENCY` = 0, `d_ready` = 1, 8 back-to-back Gets → 8 consecutive `d_valid` cycles starting at t+2.
- **Reset mid-flight:** assert `rst` for 1 cycle while 3 requests are queued → `d_valid` = 0 the next cycle, no stale responses, and a new Get completes normally.
